// File: rtl/config_port_pkg.sv
// Shared types and constants for the configuration-port arbiter and its
// session tracker.
package config_port_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] SYNC_WORD = 32'hFAB0_FAB1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    STREAM  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    HDR    = 2'd1,
    FRAME  = 2'd2
  } phase_e;

endpackage

// File: rtl/config_session_tracker.sv
// Follows the bitstream framing of the granted source (sync word, headers,
// frame bodies) so the arbiter knows when the desync header ends a session.
module config_session_tracker
  import config_port_pkg::*;
#(
  parameter int NumberOfRows = 16,
  parameter int desync_flag  = 20
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              clear,
  input  logic              xfer,
  input  logic [WORD_W-1:0] data,
  output logic              session_end
);

  localparam int RowW = $clog2(NumberOfRows + 1);

  phase_e          phase_q, phase_d;
  logic [RowW-1:0] row_q, row_d;

  assign session_end = xfer && (phase_q == HDR) && data[desync_flag];

  always_comb begin
    phase_d = phase_q;
    row_d   = row_q;
    if (clear) begin
      phase_d = UNSYNC;
    end else if (xfer) begin
      case (phase_q)
        UNSYNC: if (data == SYNC_WORD) phase_d = HDR;
        HDR: begin
          if (data[desync_flag]) begin
            phase_d = UNSYNC;
          end else begin
            row_d   = RowW'(NumberOfRows);
            phase_d = FRAME;
          end
        end
        FRAME: begin
          // Last word of the frame body hands control back to the header.
          if (row_q == RowW'(1)) phase_d = HDR;
          else                   row_d   = row_q - RowW'(1);
        end
        default: phase_d = UNSYNC;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      phase_q <= UNSYNC;
      row_q   <= '0;
    end else begin
      phase_q <= phase_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/config_port_arbiter.sv
// Round-robin arbiter granting whole configuration sessions on the single
// ConfigFSM write port to one of NumSources bitstream loaders.
module config_port_arbiter
  import config_port_pkg::*;
#(
  parameter int NumSources   = 3,
  parameter int NumberOfRows = 16,
  parameter int desync_flag  = 20,
  parameter int IdleTimeout  = 1024,
  parameter int TimeoutWidth = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [NumSources*WORD_W-1:0] src_data,
  input  logic [NumSources-1:0]      src_valid,
  output logic [NumSources-1:0]      src_ready,
  input  logic [NumSources-1:0]      src_active,
  output logic [WORD_W-1:0]          WriteData,
  output logic                       WriteStrobe,
  output logic                       FSM_Reset,
  output logic [NumSources-1:0]      Grant,
  output logic                       Busy,
  output logic                       TimeoutErr
);

  localparam int PtrW = (NumSources > 1) ? $clog2(NumSources) : 1;

  arb_state_e state_q, state_d;

  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [PtrW-1:0]         gidx_q, gidx_d;
  logic [PtrW-1:0]         sel_idx, cand;
  logic                    sel_found;
  logic [NumSources-1:0]   grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic                    fsm_reset_q, fsm_reset_d;
  logic                    write_strobe_q, write_strobe_d;
  logic [WORD_W-1:0]       write_data_q, write_data_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [TimeoutWidth-1:0] idle_q, idle_d;

  logic              active_lost, xfer, timeout_hit, session_end;
  logic [WORD_W-1:0] grant_word;

  assign src_ready   = (state_q == STREAM) ? grant_q : '0;
  assign grant_word  = src_data[gidx_q*WORD_W +: WORD_W];
  // A source that drops its active flag forfeits the word it is offering.
  assign active_lost = (state_q == STREAM) && !src_active[gidx_q];
  assign xfer        = |(src_valid & src_ready) && !active_lost;
  assign timeout_hit = (state_q == STREAM) && !xfer && !active_lost &&
                       (idle_q == TimeoutWidth'(IdleTimeout - 1));

  config_session_tracker #(
    .NumberOfRows (NumberOfRows),
    .desync_flag  (desync_flag)
  ) u_tracker (
    .CLK         (CLK),
    .reset       (reset),
    .clear       (state_q == ARM),
    .xfer        (xfer),
    .data        (grant_word),
    .session_end (session_end)
  );

  // Search starts just after the last owner so a re-requesting source waits
  // for every other active source.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NumSources; k++) begin
      cand = PtrW'((int'(ptr_q) + k) % NumSources);
      if (!sel_found && src_active[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = ARM;
      ARM:     state_d = STREAM;
      STREAM: begin
        if (active_lost || timeout_hit) state_d = IDLE;
        else if (session_end)           state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    if (state_q == IDLE && sel_found) begin
      gidx_d  = sel_idx;
      grant_d = NumSources'(1) << sel_idx;
    end
    if (state_q != IDLE && state_d == IDLE) begin
      ptr_d   = gidx_q;
      grant_d = '0;
    end
    busy_d         = (state_d != IDLE);
    fsm_reset_d    = (state_d == ARM);
    write_strobe_d = xfer;
    write_data_d   = xfer ? grant_word : write_data_q;
    timeout_err_d  = timeout_hit;
    idle_d         = (state_q == STREAM && !xfer) ? idle_q + TimeoutWidth'(1) : '0;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ptr_q          <= PtrW'(NumSources - 1);
      gidx_q         <= '0;
      grant_q        <= '0;
      busy_q         <= 1'b0;
      fsm_reset_q    <= 1'b0;
      write_strobe_q <= 1'b0;
      write_data_q   <= '0;
      timeout_err_q  <= 1'b0;
      idle_q         <= '0;
    end else begin
      ptr_q          <= ptr_d;
      gidx_q         <= gidx_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      fsm_reset_q    <= fsm_reset_d;
      write_strobe_q <= write_strobe_d;
      write_data_q   <= write_data_d;
      timeout_err_q  <= timeout_err_d;
      idle_q         <= idle_d;
    end
  end

  assign Grant       = grant_q;
  assign Busy        = busy_q;
  assign FSM_Reset   = fsm_reset_q;
  assign WriteStrobe = write_strobe_q;
  assign WriteData   = write_data_q;
  assign TimeoutErr  = timeout_err_q;

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed-plus-random bench for config_port_arbiter with a short idle
// timeout; expectations come from a session-level model of the arbiter.
module tb_config_port_arbiter;

  localparam int N    = 3;
  localparam int ROWS = 16;
  localparam int TO   = 8;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] BIT20  = 32'h0010_0000;

  logic            CLK = 1'b0;
  logic            reset;
  logic [N*32-1:0] src_data;
  logic [N-1:0]    src_valid, src_ready, src_active, Grant;
  logic [31:0]     WriteData;
  logic            WriteStrobe, FSM_Reset, Busy, TimeoutErr;

  int compared   = 0;
  int mismatched = 0;
  int rr_last;
  int strobes_seen;
  int g;
  logic [31:0] last_word;

  always #5 CLK = ~CLK;

  config_port_arbiter #(
    .NumSources   (N),
    .NumberOfRows (ROWS),
    .desync_flag  (20),
    .IdleTimeout  (TO),
    .TimeoutWidth (16)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_active  (src_active),
    .WriteData   (WriteData),
    .WriteStrobe (WriteStrobe),
    .FSM_Reset   (FSM_Reset),
    .Grant       (Grant),
    .Busy        (Busy),
    .TimeoutErr  (TimeoutErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Round-robin rule: first active source after the previous owner.
  function automatic int next_owner(input logic [N-1:0] act);
    for (int k = 1; k <= N; k++) begin
      if (act[(rr_last + k) % N]) return (rr_last + k) % N;
    end
    return 0;
  endfunction

  task automatic offer(input int src, input logic [31:0] word);
    src_valid[src] = 1'b1;
    src_data[src*32 +: 32] = word;
    tick();
    src_valid[src] = 1'b0;
    last_word = word;
    if (WriteStrobe === 1'b1) strobes_seen++;
    chk("strobe_after_xfer", 32'(WriteStrobe), 32'd1);
    chk("wdata_after_xfer", WriteData, last_word);
    chk("no_timeout_on_xfer", 32'(TimeoutErr), 32'd0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (WriteStrobe === 1'b1) strobes_seen++;
      chk("strobe_in_gap", 32'(WriteStrobe), 32'd0);
      chk("wdata_held", WriteData, last_word);
      chk("timeout_in_gap", 32'(TimeoutErr), 32'd0);
    end
  endtask

  task automatic start_session(output int owner);
    owner = next_owner(src_active);
    chk("idle_grant", 32'(Grant), 32'd0);
    chk("idle_fsm_reset_low", 32'(FSM_Reset), 32'd0);
    tick();
    chk("arm_grant", 32'(Grant), 32'd1 << owner);
    chk("arm_busy", 32'(Busy), 32'd1);
    chk("arm_fsm_reset", 32'(FSM_Reset), 32'd1);
    chk("arm_ready", 32'(src_ready), 32'd0);
    tick();
    chk("stream_fsm_reset", 32'(FSM_Reset), 32'd0);
    chk("stream_ready", 32'(src_ready), 32'd1 << owner);
  endtask

  // Sync, header, ROWS frame words with random gaps, desync header.
  // Frame words carry bit 20 so any row miscount ends the session early.
  task automatic full_session(input int owner);
    strobes_seen = 0;
    offer(owner, SYNC);
    offer(owner, $urandom & ~BIT20);
    for (int i = 0; i < ROWS; i++) begin
      gap($urandom_range(0, 2));
      offer(owner, $urandom | BIT20);
    end
    offer(owner, $urandom | BIT20);
    chk("release_grant", 32'(Grant), 32'd1 << owner);
    chk("release_ready", 32'(src_ready), 32'd0);
    chk("release_busy", 32'(Busy), 32'd1);
    tick();
    chk("end_grant", 32'(Grant), 32'd0);
    chk("end_busy", 32'(Busy), 32'd0);
    chk("end_strobe", 32'(WriteStrobe), 32'd0);
    chk("strobe_count", strobes_seen, ROWS + 3);
    rr_last = owner;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(Grant), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_fsm_reset"}, 32'(FSM_Reset), 32'd0);
    chk({tag, "_strobe"}, 32'(WriteStrobe), 32'd0);
    chk({tag, "_timeout"}, 32'(TimeoutErr), 32'd0);
    chk({tag, "_ready"}, 32'(src_ready), 32'd0);
    chk({tag, "_wdata"}, WriteData, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    src_data   = '0;
    src_valid  = '0;
    src_active = '0;
    last_word  = '0;
    rr_last    = N - 1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Round-robin with every source active: 0,1,2,0.
    src_active = 3'b111;
    for (int s = 0; s < 4; s++) begin
      start_session(g);
      chk("rr_order", g, s % N);
      full_session(g);
    end

    // Single active source.
    src_active = 3'b010;
    start_session(g);
    full_session(g);

    // Idle timeout, including a transfer landing on the timeout cycle.
    src_active = 3'b101;
    start_session(g);
    offer(g, SYNC);
    offer(g, 32'h0000_0003);
    gap(TO - 1);
    offer(g, $urandom | BIT20);
    gap(TO - 1);
    tick();
    chk("timeout_pulse", 32'(TimeoutErr), 32'd1);
    chk("timeout_grant", 32'(Grant), 32'd0);
    chk("timeout_busy", 32'(Busy), 32'd0);
    chk("timeout_strobe", 32'(WriteStrobe), 32'd0);
    rr_last = g;
    g = next_owner(src_active);
    tick();
    chk("timeout_pulse_end", 32'(TimeoutErr), 32'd0);
    chk("after_timeout_grant", 32'(Grant), 32'd1 << g);
    chk("after_timeout_fsm_reset", 32'(FSM_Reset), 32'd1);
    tick();
    chk("after_timeout_ready", 32'(src_ready), 32'd1 << g);

    // Active loss mid-frame while a word is offered.
    offer(g, SYNC);
    offer(g, $urandom & ~BIT20);
    for (int i = 0; i < 3; i++) offer(g, $urandom);
    src_active[g] = 1'b0;
    src_valid[g]  = 1'b1;
    src_data[g*32 +: 32] = ~last_word;
    tick();
    src_valid[g] = 1'b0;
    chk("loss_strobe", 32'(WriteStrobe), 32'd0);
    chk("loss_wdata", WriteData, last_word);
    chk("loss_grant", 32'(Grant), 32'd0);
    chk("loss_busy", 32'(Busy), 32'd0);
    rr_last = g;

    // Desync header coinciding with active loss: the loss wins.
    start_session(g);
    offer(g, SYNC);
    src_active    = '0;
    src_valid[g]  = 1'b1;
    src_data[g*32 +: 32] = BIT20;
    tick();
    src_valid[g] = 1'b0;
    chk("desync_loss_strobe", 32'(WriteStrobe), 32'd0);
    chk("desync_loss_wdata", WriteData, last_word);
    chk("desync_loss_grant", 32'(Grant), 32'd0);
    rr_last = g;
    tick();
    chk("no_active_idle", 32'(Grant), 32'd0);

    // Asynchronous reset in the middle of a stream.
    src_active = 3'b110;
    start_session(g);
    offer(g, SYNC);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    last_word  = '0;
    src_active = 3'b111;
    @(posedge CLK);
    #1;
    reset   = 1'b0;
    rr_last = N - 1;
    start_session(g);
    chk("post_reset_first", g, 0);
    full_session(g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
